// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer controller for the async FIFO. Keeps the binary/gray read
// pointers, a registered empty flag computed against the next pointer, a
// conservative fill level, and a one-entry valid/ready output register that
// sustains one word per cycle.
module rd_ptr_ctrl #(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 8,
   parameter int AE_THRESH  = 1
) (
   input  logic                  i_Rclk,
   input  logic                  i_Rrst_n,
   input  logic [PTR_WIDTH:0]    i_g_wptr_sync,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   input  logic                  i_ready,
   output logic [PTR_WIDTH:0]    o_b_rptr,
   output logic [PTR_WIDTH:0]    o_g_rptr,
   output logic                  o_empty,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic [PTR_WIDTH:0]    o_level,
   output logic                  o_almost_empty
);

   localparam int PW = PTR_WIDTH + 1;
   localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Prefix XOR from the MSB down recovers the binary count.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic          pop;
   logic [PW-1:0] b_next;
   logic [PW-1:0] g_next;
   logic [PW-1:0] w_bin;
   logic [PW-1:0] lvl_next;

   // Pop decision and next-pointer / next-level arithmetic.
   always_comb begin
      pop      = !o_empty && (!o_valid || i_ready);
      b_next   = o_b_rptr + {{(PW-1){1'b0}}, pop};
      g_next   = bin2gray(b_next);
      w_bin    = gray2bin(i_g_wptr_sync);
      lvl_next = w_bin - b_next;
   end

   // Pointers, empty and level are all judged against the next pointer so
   // popping the last word raises empty on the same edge.
   always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
      if (!i_Rrst_n) begin
         o_b_rptr       <= '0;
         o_g_rptr       <= '0;
         o_empty        <= 1'b1;
         o_level        <= '0;
         o_almost_empty <= 1'b1;
      end else begin
         o_b_rptr       <= b_next;
         o_g_rptr       <= g_next;
         o_empty        <= (g_next == i_g_wptr_sync);
         o_level        <= lvl_next;
         o_almost_empty <= (lvl_next <= AE_LIMIT);
      end
   end

   // Output register: load on pop (accept-and-reload in one edge), drop valid
   // on a plain acceptance, otherwise hold steady.
   always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
      if (!i_Rrst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else if (pop) begin
         o_data  <= i_rd_data;
         o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a count-based model of the FIFO read side.
module tb_rd_ptr_ctrl;

   logic       i_Rclk = 1'b0;
   logic       i_Rrst_n;
   logic [3:0] i_g_wptr_sync;
   logic [7:0] i_rd_data;
   logic       i_ready;
   logic [3:0] o_b_rptr;
   logic [3:0] o_g_rptr;
   logic       o_empty;
   logic [7:0] o_data;
   logic       o_valid;
   logic [3:0] o_level;
   logic       o_almost_empty;

   rd_ptr_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(1)) dut (
      .i_Rclk(i_Rclk), .i_Rrst_n(i_Rrst_n), .i_g_wptr_sync(i_g_wptr_sync),
      .i_rd_data(i_rd_data), .i_ready(i_ready), .o_b_rptr(o_b_rptr),
      .o_g_rptr(o_g_rptr), .o_empty(o_empty), .o_data(o_data),
      .o_valid(o_valid), .o_level(o_level), .o_almost_empty(o_almost_empty)
   );

   always #5 i_Rclk = ~i_Rclk;

   // FIFO storage seen by the controller (combinational read).
   logic [7:0] mem [8];
   assign i_rd_data = mem[o_b_rptr[2:0]];

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: counts of words written / popped from memory, mod 16.
   int         wcount;
   int         m_rp;
   bit         m_empty, m_valid;
   logic [7:0] m_data;
   logic [7:0] acc[$];

   function automatic logic [3:0] gray(input int v);
      return 4'(v ^ (v >> 1));
   endfunction

   function automatic bit room();
      return ((wcount - m_rp + 16) % 16) < 8;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rp = 0; m_empty = 1; m_valid = 0; m_data = 8'h00;
   endtask

   task automatic wr(input logic [7:0] v);
      mem[wcount % 8] = v;
      wcount = (wcount + 1) % 16;
      i_g_wptr_sync = gray(wcount);
   endtask

   // One clock: predict from pre-edge state, then compare every output.
   task automatic cycle();
      bit         pop;
      int         n_rp, n_level;
      bit         n_empty, n_valid;
      logic [7:0] n_data;
      if (o_valid && i_ready) acc.push_back(o_data);
      pop     = !m_empty && (!m_valid || i_ready);
      n_rp    = (m_rp + (pop ? 1 : 0)) % 16;
      n_empty = (n_rp == wcount);
      n_level = (wcount - n_rp + 16) % 16;
      n_data  = pop ? mem[m_rp % 8] : m_data;
      n_valid = pop ? 1'b1 : ((m_valid && i_ready) ? 1'b0 : m_valid);
      @(posedge i_Rclk);
      #1;
      m_rp = n_rp; m_empty = n_empty; m_valid = n_valid; m_data = n_data;
      check("b_rptr", 32'(o_b_rptr), 32'(m_rp));
      check("g_rptr", 32'(o_g_rptr), 32'(gray(m_rp)));
      check("empty", 32'(o_empty), 32'(m_empty));
      check("valid", 32'(o_valid), 32'(m_valid));
      check("data", 32'(o_data), 32'(m_data));
      check("level", 32'(o_level), 32'(n_level));
      check("almost_empty", 32'(o_almost_empty), 32'(n_level <= 1));
      @(negedge i_Rclk);
   endtask

   // Asynchronous reset between edges; outputs must clear with no clock edge.
   task automatic do_reset();
      #2;
      i_Rrst_n = 1'b0;
      wcount = 0;
      i_g_wptr_sync = 4'h0;
      #1;
      check("rst_b_rptr", 32'(o_b_rptr), 32'h0);
      check("rst_g_rptr", 32'(o_g_rptr), 32'h0);
      check("rst_empty", 32'(o_empty), 32'h1);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_data", 32'(o_data), 32'h0);
      check("rst_level", 32'(o_level), 32'h0);
      check("rst_ae", 32'(o_almost_empty), 32'h1);
      model_reset();
      acc.delete();
      @(negedge i_Rclk);
      i_Rrst_n = 1'b1;
   endtask

   task automatic check_acc(input string name, input logic [7:0] base, input int n);
      check({name, "_count"}, 32'(acc.size()), 32'(n));
      for (int i = 0; i < n && i < acc.size(); i++)
         check(name, 32'(acc[i]), 32'(8'(base + 8'(i))));
   endtask

   initial begin
      i_Rrst_n = 1'b1; i_ready = 1'b0; i_g_wptr_sync = 4'h0; wcount = 0;
      for (int a = 0; a < 8; a++) mem[a] = 8'h00;
      model_reset();
      @(negedge i_Rclk);
      do_reset();

      // Idle: nothing written.
      repeat (10) cycle();
      check("idle_empty", 32'(o_empty), 32'h1);
      check("idle_level", 32'(o_level), 32'h0);

      // Single word: empty falls after 1 cycle, valid after 2.
      i_ready = 1'b1;
      wr(8'hA5);
      cycle();
      check("one_empty_fall", 32'(o_empty), 32'h0);
      check("one_valid_low", 32'(o_valid), 32'h0);
      check("one_level", 32'(o_level), 32'h1);
      cycle();
      check("one_valid", 32'(o_valid), 32'h1);
      check("one_data", 32'(o_data), 32'hA5);
      check("one_rptr", 32'(o_b_rptr), 32'h1);
      check("one_empty_back", 32'(o_empty), 32'h1);
      cycle();
      check("one_valid_drop", 32'(o_valid), 32'h0);

      // Full burst with ready held high.
      do_reset();
      for (int a = 0; a < 8; a++) mem[a] = 8'(8'h10 + a);
      wcount = 8; i_g_wptr_sync = gray(8);
      i_ready = 1'b1;
      repeat (12) begin
         cycle();
         if (o_level == 4'd1) check("burst_ae_at1", 32'(o_almost_empty), 32'h1);
      end
      check_acc("burst_data", 8'h10, 8);
      check("burst_empty", 32'(o_empty), 32'h1);
      check("burst_g_rptr", 32'(o_g_rptr), 32'hC);

      // Full fill with back-pressure: exactly one pop, then resume.
      do_reset();
      for (int a = 0; a < 8; a++) mem[a] = 8'(8'h10 + a);
      wcount = 8; i_g_wptr_sync = gray(8);
      i_ready = 1'b0;
      repeat (5) cycle();
      check("bp_data", 32'(o_data), 32'h10);
      check("bp_rptr", 32'(o_b_rptr), 32'h1);
      check("bp_level", 32'(o_level), 32'h7);
      i_ready = 1'b1;
      repeat (12) cycle();
      check_acc("bp_resume", 8'h10, 8);

      // Wrap-around: advance both counts to 14, then write 4 more.
      do_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 200 && !(m_rp == 14 && !m_valid); i++) begin
         if (wcount < 14 && room()) wr(8'($urandom));
         cycle();
      end
      check("wrap_pre_rptr", 32'(o_b_rptr), 32'd14);
      acc.delete();
      wr(8'hC6); wr(8'hC7); wr(8'hC8); wr(8'hC9);
      cycle();
      check("wrap_level", 32'(o_level), 32'h4);
      check("wrap_rptr_hold", 32'(o_b_rptr), 32'd14);
      repeat (8) cycle();
      check("wrap_rptr", 32'(o_b_rptr), 32'h2);
      check_acc("wrap_data", 8'hC6, 4);

      // Randomized traffic with one mid-stream reset.
      for (int i = 0; i < 1500; i++) begin
         i_ready = 1'($urandom_range(0, 1));
         if (room() && $urandom_range(0, 1) == 1) wr(8'($urandom));
         cycle();
         if (i == 700) begin
            i_ready = 1'b0;
            for (int k = 0; k < 30 && !o_valid; k++) begin
               if (room()) wr(8'($urandom));
               cycle();
            end
            check("mid_valid_before_reset", 32'(o_valid), 32'h1);
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rd_ptr_ctrl.md
Name: rd_ptr_ctrl

Overview:
- Read-side controller of the async FIFO. It consumes the gray write pointer after it has been synchronized into the read domain.
- Maintains the binary and gray read pointers and the registered empty flag.
- Drives the memory read address and presents popped words through a one-entry valid/ready output register.
- Reports fill level and almost-empty to downstream SerDes logic, for example the serializer's frame-start decision.

Parameters:
- PTR_WIDTH, 3: address bits. FIFO depth = 2**PTR_WIDTH (8). Pointers are PTR_WIDTH+1 bits, with the MSB as the wrap bit.
- DATA_WIDTH, 8: width of the memory read data and the output word.
- AE_THRESH, 1: o_almost_empty asserts when the memory level is <= AE_THRESH.

Ports:
- i_Rclk  input  1  read-domain clock
- i_Rrst_n  input  1  asynchronous, active-low reset
- i_g_wptr_sync  input  PTR_WIDTH+1  gray write pointer, already 2-flop synchronized into i_Rclk
- i_rd_data  input  DATA_WIDTH  memory read data; combinational read at address o_b_rptr[PTR_WIDTH-1:0]
- i_ready  input  1  downstream accepts o_data this cycle
- o_b_rptr  output  PTR_WIDTH+1  binary read pointer; low PTR_WIDTH bits are the memory address
- o_g_rptr  output  PTR_WIDTH+1  gray read pointer, sent to the write-domain synchronizer
- o_empty  output  1  memory holds no unread words (registered)
- o_data  output  DATA_WIDTH  output register contents
- o_valid  output  1  o_data holds a word not yet accepted
- o_level  output  PTR_WIDTH+1  words in memory, excluding the output register (registered, 0..2**PTR_WIDTH)
- o_almost_empty  output  1  o_level <= AE_THRESH (registered)

Behaviour:
- Reset (async on i_Rrst_n low; release is synchronous to i_Rclk):
  - o_b_rptr=0, o_g_rptr=0
  - o_empty=1, o_valid=0, o_data=0
  - o_level=0, o_almost_empty=1
- Pop condition: pop = !o_empty && (!o_valid || i_ready). Pop is the only event that advances the read pointers.
- Pointer update:
  - b_next = o_b_rptr + pop, modulo 2**(PTR_WIDTH+1)
  - g_next = (b_next>>1) ^ b_next
  - Both are registered every cycle. The gray pointer changes by exactly one bit per pop.
- Empty flag: o_empty <= (g_next == i_g_wptr_sync), registered every cycle.
  - It is evaluated against the next pointer, so popping the last word raises o_empty on the same edge that advances the pointer.
  - No read ever occurs while o_empty=1.
- Output register:
  - On pop: o_data <= i_rd_data (addressed by the current o_b_rptr), and o_valid <= 1.
  - Else if o_valid && i_ready: o_valid <= 0, and o_data holds its value.
  - Else: hold.
  - When o_valid=1 and i_ready=1 with memory non-empty, the old word is accepted and the next word is loaded on the same edge. This sustains one word per cycle with no bubble.
  - o_data and o_valid must remain stable while o_valid=1 and i_ready=0.
- Level:
  - w_bin = gray-to-binary of i_g_wptr_sync, computed as a prefix XOR from the MSB down.
  - o_level <= (w_bin - b_next), modulo 2**(PTR_WIDTH+1).
  - o_almost_empty <= (that same value <= AE_THRESH).
  - The level is conservative: it can lag the true level by the synchronizer delay and never overstates it.
- Wrap-around: pointers roll over from 2**(PTR_WIDTH+1)-1 to 0. The wrap bit keeps empty and level correct across the rollover.
- Latency: once i_g_wptr_sync changes, o_empty falls 1 cycle later. o_valid rises on the following edge, 2 cycles total, provided o_valid was 0.
- Simultaneous events: the write pointer advancing on the same cycle as a last-word pop is handled by the registered compare. o_empty may stay 1 for one extra cycle, which is acceptable; a spurious non-empty is not.
- Reset mid-operation: all state clears immediately. Any word in the output register is discarded, and o_valid drops asynchronously.

Test Plan:
- Reset, then i_g_wptr_sync=0 for 10 cycles -> o_empty=1, o_valid=0, o_level=0, o_almost_empty=1, o_b_rptr=0 throughout.
- i_g_wptr_sync steps to gray(1)=0001 with i_ready=1 and i_rd_data=8'hA5 -> o_empty=0 one cycle later. o_valid=1 and o_data=A5 the next cycle. o_b_rptr=1, o_empty=1 again, o_valid drops after acceptance.
- i_g_wptr_sync=gray(8)=1100, i_ready held 1, i_rd_data = address+8'h10 -> o_data=10..17 on 8 consecutive cycles. o_level counts 7..0, and o_almost_empty asserts at level 1. o_empty=1 and o_g_rptr=1100 at the end.
- Same fill with i_ready=0 -> exactly one pop. o_data=10 stays stable and o_b_rptr=1 with o_level=7. Raising i_ready resumes at 11 with no loss or duplication.
- Preload pointers to 14 via 14 pops, then set i_g_wptr_sync=gray(2)=0011 -> 4 words are read at addresses 6,7,0,1. o_b_rptr wraps 15->0->1->2 and o_level=4 before the reads.
- Assert i_Rrst_n low mid-stream with o_valid=1 -> all outputs return to reset values without waiting for an i_Rclk edge. Normal pops resume after release.
